// File: rtl/adder_arbiter.sv
// Round-robin sequencer that time-shares one external WIDTH-bit adder between
// REQUESTERS clients and returns each tagged sum with its carry-out.
module adder_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ID_W       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REQUESTERS-1:0]         req_valid,
  output logic [REQUESTERS-1:0]         req_ready,
  input  logic [WIDTH*REQUESTERS-1:0]   req_a,
  input  logic [WIDTH*REQUESTERS-1:0]   req_b,
  output logic [WIDTH-1:0]              add_a,
  output logic [WIDTH-1:0]              add_b,
  input  logic [WIDTH-1:0]              add_c,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [WIDTH-1:0]              resp_sum,
  output logic                          resp_carry,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_hit;
  int unsigned     cand;

  logic [WIDTH-1:0] op_a [REQUESTERS];
  logic [WIDTH-1:0] op_b [REQUESTERS];

  // Unpack the flat client operand buses.
  for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
    assign op_a[i] = req_a[i*WIDTH +: WIDTH];
    assign op_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search beginning one past the previous winner.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      cand = (32'(last_grant) + 32'd1 + k) % REQUESTERS;
      if (!grant_hit && req_valid[ID_W'(cand)]) begin
        grant_hit = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_hit)
      req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(REQUESTERS - 1);
      add_a      <= '0;
      add_b      <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            add_a      <= op_a[grant_idx];
            add_b      <= op_b[grant_idx];
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // A wrapped sum is smaller than either operand exactly when carry-out is set.
          resp_sum   <= add_c;
          resp_carry <= (add_c < add_a);
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized scoreboard bench for adder_arbiter with a cycle-level reference model.
module tb_adder_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_c;
  logic           resp_valid, resp_ready, resp_carry, busy;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_sum;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int id1_seen = 0;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  assign add_c = add_a + add_b;

  adder_arbiter #(.REQUESTERS(N), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: phase counter plus rotating priority, evaluated mid-cycle.
  int m_phase = 0;
  int m_last  = N - 1;

  always @(negedge clock) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic [W:0]   s;
    if (reset) begin
      check("rst_req_ready", 64'(req_ready), 64'(0));
      exp_q.delete();
      m_phase = 0;
      m_last  = N - 1;
    end else begin
      g = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < int'(N); k++) begin
          int c;
          c = (m_last + 1 + k) % int'(N);
          if (g < 0 && req_valid[c[1:0]]) g = c;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("resp_valid", 64'(resp_valid), 64'(m_phase == 2));
      case (m_phase)
        0: if (g >= 0) begin
             s = {1'b0, op_a[g]} + {1'b0, op_b[g]};
             exp_q.push_back('{id: g[1:0], sum: s[W-1:0], carry: s[W]});
             m_last  = g;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: consumes responses and checks hold-stability under backpressure.
  logic         hold_pend = 1'b0;
  logic [1:0]   held_id;
  logic [W-1:0] held_sum;
  logic         held_carry;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hold_pend = 1'b0;
    end else if (resp_valid) begin
      if (hold_pend) begin
        check("hold_id", 64'(resp_id), 64'(held_id));
        check("hold_sum", 64'(resp_sum), 64'(held_sum));
        check("hold_carry", 64'(resp_carry), 64'(held_carry));
      end
      if (resp_ready) begin
        check("resp_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_id", 64'(resp_id), 64'(e.id));
          check("resp_sum", 64'(resp_sum), 64'(e.sum));
          check("resp_carry", 64'(resp_carry), 64'(e.carry));
        end
        if (resp_id == 2'd1) id1_seen++;
        hold_pend = 1'b0;
      end else begin
        hold_pend  = 1'b1;
        held_id    = resp_id;
        held_sum   = resp_sum;
        held_carry = resp_carry;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Advance one cycle; accepted clients either drop valid or reload new operands.
  task automatic tick(input bit keep);
    logic [N-1:0] acc;
    @(negedge clock);
    acc = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (acc[i]) begin
        if (keep) begin
          op_a[i] = $urandom;
          op_b[i] = $urandom;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_valid[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : W'($urandom);
  endfunction

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset values
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_add_a", 64'(add_a), 64'(0));
    check("rst_add_b", 64'(add_b), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_sum", 64'(resp_sum), 64'(0));
    check("rst_resp_carry", 64'(resp_carry), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // Single request and overflow wrap
    resp_ready = 1'b1;
    set_req(2, 32'd5, 32'd7);
    repeat (5) tick(1'b0);
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
    repeat (5) tick(1'b0);

    // All clients requesting continuously
    for (int i = 0; i < int'(N); i++) set_req(i, W'($urandom), W'($urandom));
    repeat (16) tick(1'b1);
    req_valid = '0;
    repeat (4) tick(1'b0);

    // Backpressure with a second client pending
    resp_ready = 1'b0;
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    set_req(2, 32'd100, 32'd23);
    repeat (14) tick(1'b0);
    resp_ready = 1'b1;
    repeat (8) tick(1'b0);

    // Reset while a response is pending
    resp_ready = 1'b0;
    set_req(2, 32'h1234, 32'h4321);
    repeat (4) tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_add_a", 64'(add_a), 64'(0));
    @(posedge clock); #1;
    resp_ready = 1'b1;
    set_req(0, 32'd1, 32'd2);
    set_req(3, 32'd3, 32'd4);
    repeat (8) tick(1'b0);

    // Withdrawn request while another client is served
    id1_seen = 0;
    set_req(3, 32'd9, 32'd9);
    tick(1'b0);
    set_req(1, 32'd77, 32'd88);
    tick(1'b0);
    tick(1'b0);
    req_valid[1] = 1'b0;
    repeat (4) tick(1'b0);
    check("withdrawn_never_granted", 64'(id1_seen), 64'(0));

    // Randomized traffic
    repeat (3000) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rnd_op(), rnd_op());
        else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      tick(1'b0);
    end

    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) tick(1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
